// File: rtl/wb_stage_pkg.sv
// Shared pipeline definitions used by the MEM and WB stages.
// Holds the load-size encodings and the register-file address width.
package wb_stage_pkg;

   localparam int REG_ADDR_W = 5;

   typedef enum logic [1:0] {
      LD_WORD = 2'b00,
      LD_HALF = 2'b01,
      LD_BYTE = 2'b10,
      LD_RSVD = 2'b11
   } ld_size_e;

endpackage : wb_stage_pkg

// File: rtl/wb_stage_load_align.sv
// Sub-word load extraction: selects a byte or halfword lane from the read word
// (little-endian) and sign- or zero-extends it to the full datapath width.
module load_align
   import wb_stage_pkg::*;
#(
   parameter int DATA_W = 32
) (
   input  logic [DATA_W-1:0] m_o,
   input  logic [1:0]        ld_size,
   input  logic              ld_signed,
   input  logic [1:0]        addr_lo,
   output logic [DATA_W-1:0] ld_data
);

   logic [7:0]        byte_s;
   logic [15:0]       half_s;
   logic              byte_fill_s;
   logic              half_fill_s;
   logic [DATA_W-1:0] ld_data_s;

   // Lane selection and extension; the reserved size encoding behaves as a word load.
   always_comb begin
      byte_s      = m_o[{addr_lo, 3'b000} +: 8];
      half_s      = m_o[{addr_lo[1], 4'b0000} +: 16];
      byte_fill_s = ld_signed & byte_s[7];
      half_fill_s = ld_signed & half_s[15];
      ld_data_s   = m_o;
      case (ld_size)
         LD_BYTE: ld_data_s = {{(DATA_W-8){byte_fill_s}}, byte_s};
         LD_HALF: ld_data_s = {{(DATA_W-16){half_fill_s}}, half_s};
         LD_WORD: ld_data_s = m_o;
         default: ld_data_s = m_o;
      endcase
   end

   assign ld_data = ld_data_s;

endmodule : load_align

// File: rtl/wb_stage.sv
// Writeback stage: selects ALU or load data for the register file, qualifies
// the write enable against r0 and keeps a one-cycle forwarding copy.
module wb_stage
   import wb_stage_pkg::*;
#(
   parameter int DATA_W     = 32,
   parameter int LOAD_ALIGN = 0
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [DATA_W-1:0]     r_alu,
   input  logic [DATA_W-1:0]     m_o,
   input  logic                  m2reg,
   input  logic                  wreg,
   input  logic [REG_ADDR_W-1:0] wn,
   input  logic [1:0]            ld_size,
   input  logic                  ld_signed,
   input  logic [1:0]            addr_lo,
   output logic [DATA_W-1:0]     wdi,
   output logic                  we_out,
   output logic [REG_ADDR_W-1:0] wn_out,
   output logic [DATA_W-1:0]     fwd_data,
   output logic [REG_ADDR_W-1:0] fwd_wn,
   output logic                  fwd_valid
);

   logic [DATA_W-1:0]     load_data_s;
   logic [DATA_W-1:0]     wdi_s;
   logic                  we_s;
   logic [DATA_W-1:0]     fwd_data_r;
   logic [REG_ADDR_W-1:0] fwd_wn_r;
   logic                  fwd_valid_r;

   generate
      if (LOAD_ALIGN == 1) begin : g_align
         load_align #(
            .DATA_W (DATA_W)
         ) u_load_align (
            .m_o       (m_o),
            .ld_size   (ld_size),
            .ld_signed (ld_signed),
            .addr_lo   (addr_lo),
            .ld_data   (load_data_s)
         );
      end else begin : g_pass
         // Sub-word controls have no meaning on this path; fold them into a sink.
         logic unused_ld_s;
         assign unused_ld_s = ^{ld_size, ld_signed, addr_lo};
         assign load_data_s = m_o;
      end
   endgenerate

   // Writeback mux and r0-suppressed write enable, no clock latency.
   always_comb begin
      wdi_s = r_alu;
      if (m2reg) begin
         wdi_s = load_data_s;
      end else begin
         wdi_s = r_alu;
      end
      we_s = wreg & (wn != 5'd0);
   end

   // Forwarding copy of last cycle's writeback; reset wins over capture.
   always_ff @(posedge clk) begin
      if (rst) begin
         fwd_data_r  <= '0;
         fwd_wn_r    <= 5'd0;
         fwd_valid_r <= 1'b0;
      end else begin
         fwd_data_r  <= wdi_s;
         fwd_wn_r    <= wn;
         fwd_valid_r <= we_s;
      end
   end

   assign wdi       = wdi_s;
   assign we_out    = we_s;
   assign wn_out    = wn;
   assign fwd_data  = fwd_data_r;
   assign fwd_wn    = fwd_wn_r;
   assign fwd_valid = fwd_valid_r;

endmodule : wb_stage

// File: tb/tb_wb_stage.sv
// Self-checking bench for wb_stage: directed cases plus randomized cycles,
// comparing both the pass-through and the load-align builds against a model.
module tb_wb_stage;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] r_alu, m_o;
   logic        m2reg, wreg, ld_signed;
   logic [4:0]  wn;
   logic [1:0]  ld_size, addr_lo;

   logic [31:0] wdi0, fwd_data0, wdi1, fwd_data1;
   logic        we_out0, fwd_valid0, we_out1, fwd_valid1;
   logic [4:0]  wn_out0, fwd_wn0, wn_out1, fwd_wn1;

   int checks = 0;
   int errors = 0;

   logic [31:0] exp_fd0, exp_fd1;
   logic [4:0]  exp_fwn;
   logic        exp_fv;

   always #5 clk = ~clk;

   wb_stage #(.DATA_W(32), .LOAD_ALIGN(0)) u_dut0 (
      .clk(clk), .rst(rst), .r_alu(r_alu), .m_o(m_o), .m2reg(m2reg), .wreg(wreg),
      .wn(wn), .ld_size(ld_size), .ld_signed(ld_signed), .addr_lo(addr_lo),
      .wdi(wdi0), .we_out(we_out0), .wn_out(wn_out0),
      .fwd_data(fwd_data0), .fwd_wn(fwd_wn0), .fwd_valid(fwd_valid0)
   );

   wb_stage #(.DATA_W(32), .LOAD_ALIGN(1)) u_dut1 (
      .clk(clk), .rst(rst), .r_alu(r_alu), .m_o(m_o), .m2reg(m2reg), .wreg(wreg),
      .wn(wn), .ld_size(ld_size), .ld_signed(ld_signed), .addr_lo(addr_lo),
      .wdi(wdi1), .we_out(we_out1), .wn_out(wn_out1),
      .fwd_data(fwd_data1), .fwd_wn(fwd_wn1), .fwd_valid(fwd_valid1)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Reference load value computed arithmetically from the lane rules.
   function automatic logic [31:0] model_load(input logic [31:0] m, input logic [1:0] size,
                                              input logic sgn, input logic [1:0] off);
      longint v;
      if (size == 2'd2) begin
         v = (m >> (8 * off)) % 256;
         if (sgn && v >= 128) v = v - 256;
      end else if (size == 2'd1) begin
         v = (m >> (8 * (off / 2 * 2))) % 65536;
         if (sgn && v >= 32768) v = v - 65536;
      end else begin
         v = m;
      end
      return v[31:0];
   endfunction

   function automatic logic [31:0] model_wdi(input bit align);
      if (!m2reg) return r_alu;
      return align ? model_load(m_o, ld_size, ld_signed, addr_lo) : m_o;
   endfunction

   task automatic check_comb(input string tag);
      check({tag, "_wdi0"}, wdi0, model_wdi(1'b0));
      check({tag, "_wdi1"}, wdi1, model_wdi(1'b1));
      check({tag, "_we0"}, {31'd0, we_out0}, {31'd0, wreg && wn != 5'd0});
      check({tag, "_we1"}, {31'd0, we_out1}, {31'd0, wreg && wn != 5'd0});
      check({tag, "_wn0"}, {27'd0, wn_out0}, {27'd0, wn});
      check({tag, "_wn1"}, {27'd0, wn_out1}, {27'd0, wn});
   endtask

   task automatic check_fwd(input string tag);
      check({tag, "_fd0"}, fwd_data0, exp_fd0);
      check({tag, "_fd1"}, fwd_data1, exp_fd1);
      check({tag, "_fwn0"}, {27'd0, fwd_wn0}, {27'd0, exp_fwn});
      check({tag, "_fwn1"}, {27'd0, fwd_wn1}, {27'd0, exp_fwn});
      check({tag, "_fv0"}, {31'd0, fwd_valid0}, {31'd0, exp_fv});
      check({tag, "_fv1"}, {31'd0, fwd_valid1}, {31'd0, exp_fv});
   endtask

   initial begin
      rst = 1'b1; r_alu = 32'd0; m_o = 32'd0; m2reg = 1'b0; wreg = 1'b0;
      wn = 5'd0; ld_size = 2'd0; ld_signed = 1'b0; addr_lo = 2'd0;

      // Reset state
      @(posedge clk); @(posedge clk); @(negedge clk);
      exp_fd0 = 32'd0; exp_fd1 = 32'd0; exp_fwn = 5'd0; exp_fv = 1'b0;
      check_fwd("reset");
      rst = 1'b0;

      // ALU/memory select follows m2reg without latency
      r_alu = 32'd1; m_o = 32'd2; m2reg = 1'b0;
      #1 check("mux_alu", wdi0, 32'd1);
      #50 m2reg = 1'b1;
      #1 check("mux_mem0", wdi0, 32'd2);
      check("mux_mem1", wdi1, 32'd2);

      // Sub-word extraction on a fixed pattern
      @(negedge clk);
      m_o = 32'h8070_F0A5; m2reg = 1'b1;
      ld_size = 2'b10; ld_signed = 1'b1; addr_lo = 2'd0;
      #1 check("byte_s0", wdi1, 32'hFFFF_FFA5);
      check("noalign", wdi0, 32'h8070_F0A5);
      ld_signed = 1'b0; addr_lo = 2'd1;
      #1 check("byte_u1", wdi1, 32'h0000_00F0);
      ld_size = 2'b01; ld_signed = 1'b1; addr_lo = 2'd2;
      #1 check("half_s2", wdi1, 32'hFFFF_8070);
      ld_signed = 1'b0;
      #1 check("half_u2", wdi1, 32'h0000_8070);
      addr_lo = 2'd3;
      #1 check("half_u3", wdi1, 32'h0000_8070);
      ld_size = 2'b11;
      #1 check("size11", wdi1, 32'h8070_F0A5);

      // Write-enable qualification
      wreg = 1'b1; wn = 5'd0;
      #1 check("we_r0", {31'd0, we_out1}, 32'd0);
      wn = 5'd5;
      #1 check("we_r5", {31'd0, we_out1}, 32'd1);
      check("wn_r5", {27'd0, wn_out1}, 32'd5);

      // Forwarding capture, then reset priority
      @(negedge clk);
      wreg = 1'b1; wn = 5'd7; m2reg = 1'b0; r_alu = 32'h0000_1234;
      @(posedge clk); #1;
      exp_fd0 = 32'h1234; exp_fd1 = 32'h1234; exp_fwn = 5'd7; exp_fv = 1'b1;
      check_fwd("fwd");
      @(negedge clk); rst = 1'b1;
      #1 check_comb("rst_comb");
      @(posedge clk); #1;
      exp_fd0 = 32'd0; exp_fd1 = 32'd0; exp_fwn = 5'd0; exp_fv = 1'b0;
      check_fwd("fwd_rst");

      // Randomized cycles
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         rst       = ($urandom_range(0, 15) == 0);
         r_alu     = $urandom;
         m_o       = $urandom;
         m2reg     = $urandom_range(0, 1) == 1;
         wreg      = $urandom_range(0, 1) == 1;
         wn        = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom);
         ld_size   = 2'($urandom);
         ld_signed = $urandom_range(0, 1) == 1;
         addr_lo   = 2'($urandom);
         #1 check_comb("rnd");
         if (rst) begin
            exp_fd0 = 32'd0; exp_fd1 = 32'd0; exp_fwn = 5'd0; exp_fv = 1'b0;
         end else begin
            exp_fd0 = model_wdi(1'b0); exp_fd1 = model_wdi(1'b1);
            exp_fwn = wn; exp_fv = wreg && wn != 5'd0;
         end
         @(posedge clk); #1;
         check_fwd("rnd");
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule : tb_wb_stage
